// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall encodings,
// stage indices and multi-cycle sequencer states.
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif

package pipe_ctrl_pkg;

   localparam int ST_PC  = 0;
   localparam int ST_IF  = 1;
   localparam int ST_ID  = 2;
   localparam int ST_EX  = 3;
   localparam int ST_MEM = 4;
   localparam int ST_WB  = 5;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   typedef enum logic {
      IDLE    = 1'b0,
      MC_BUSY = 1'b1
   } mc_state_t;

endpackage

// File: rtl/pipe_mc_counter.sv
// Loadable countdown for multi-cycle EX operations; holds while MEM
// stalls and flags the final cycle.
module pipe_mc_counter #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         hold,
   input  logic         clear,
   output logic [W-1:0] count,
   output logic         last
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (!hold && count != '0) begin
         count <= count - W'(1);
      end
   end

   assign last = (count == W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall vector, multi-cycle EX sequencing,
// deferred branch kill and exception flush.
`ifndef InstAddrBus
`define InstAddrBus 31:0
`endif

module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MC_CNT_W = 6,
   parameter int PERF_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stallreq_if,
   input  logic                stallreq_id,
   input  logic                stallreq_mem,
   input  logic                mc_start,
   input  logic [MC_CNT_W-1:0] mc_len,
   input  logic                br_req,
   input  logic                exc_req,
   input  logic [`InstAddrBus] exc_pc,
   output logic [5:0]          stall,
   output logic                br,
   output logic                flush,
   output logic [`InstAddrBus] new_pc,
   output logic                mc_busy,
   output logic                mc_done,
   output logic [PERF_W-1:0]   stall_cnt
);

   mc_state_t           state;
   logic                br_pend;
   logic [MC_CNT_W-1:0] count;
   logic                last;
   logic                issue;
   logic                mc_load;
   logic [5:0]          stall_raw;

   assign issue   = (state == IDLE) && mc_start
                    && (mc_len >= MC_CNT_W'(2));
   assign mc_load = issue && !exc_req;

   always_comb begin
      stall_raw = STALL_NONE;
      if (exc_req)
         stall_raw = STALL_NONE;
      else if (stallreq_mem)
         stall_raw = STALL_MEM;
      else if (state == MC_BUSY && !last)
         stall_raw = STALL_EX;
      else if (issue)
         stall_raw = STALL_EX;
      else if (stallreq_id)
         stall_raw = STALL_ID;
      else if (stallreq_if)
         stall_raw = STALL_IF;
   end

   // Outputs are forced quiet while reset is held, independent of inputs.
   assign stall   = rst ? STALL_NONE : stall_raw;
   assign flush   = !rst && exc_req;
   assign new_pc  = flush ? exc_pc : '0;
   assign br      = !rst && (br_req || br_pend)
                    && !stall[ST_IF] && !flush;
   assign mc_busy = (state == MC_BUSY);
   assign mc_done = !rst && (state == MC_BUSY) && last
                    && !stallreq_mem && !exc_req;

   pipe_mc_counter #(
      .W(MC_CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (mc_load),
      .load_val (mc_len - MC_CNT_W'(1)),
      .hold     (stallreq_mem),
      .clear    (exc_req),
      .count    (count),
      .last     (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else if (exc_req) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE:    if (mc_load) state <= MC_BUSY;
            MC_BUSY: if (mc_done) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // A branch seen while only IF is held waits here; when ID is also
   // frozen the branch is re-presented, so it is not captured.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_pend <= 1'b0;
      end else if (flush || br) begin
         br_pend <= 1'b0;
      end else if (br_req && stall[ST_IF] && !stall[ST_ID]) begin
         br_pend <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall != STALL_NONE && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by
// random traffic, compared against a cycle-level reference model.
module tb_pipe_ctrl;

   localparam int MCW  = 6;
   localparam int PW   = 8;
   localparam int PMAX = (1 << PW) - 1;

   logic           clk = 1'b0;
   logic           rst;
   logic           stallreq_if, stallreq_id, stallreq_mem;
   logic           mc_start;
   logic [MCW-1:0] mc_len;
   logic           br_req, exc_req;
   logic [31:0]    exc_pc;
   logic [5:0]     stall;
   logic           br, flush, mc_busy, mc_done;
   logic [31:0]    new_pc;
   logic [PW-1:0]  stall_cnt;

   int checks = 0;
   int passed = 0;

   // reference model state
   bit m_busy;
   int m_left;
   bit m_pend;
   int m_cnt;

   pipe_ctrl #(.MC_CNT_W(MCW), .PERF_W(PW)) dut (
      .clk(clk), .rst(rst),
      .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
      .stallreq_mem(stallreq_mem), .mc_start(mc_start),
      .mc_len(mc_len), .br_req(br_req), .exc_req(exc_req),
      .exc_pc(exc_pc), .stall(stall), .br(br), .flush(flush),
      .new_pc(new_pc), .mc_busy(mc_busy), .mc_done(mc_done),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic idle_inputs();
      stallreq_if = 0; stallreq_id = 0; stallreq_mem = 0;
      mc_start = 0; mc_len = '0; br_req = 0; exc_req = 0;
      exc_pc = '0;
   endtask

   task automatic model_reset();
      m_busy = 0; m_left = 0; m_pend = 0; m_cnt = 0;
   endtask

   // One clock: check outputs at the falling edge, advance the model
   // at the rising edge, then leave 1 time unit for new stimulus.
   task automatic cyc();
      logic [5:0] e_st;
      bit e_br, e_done, start;
      @(negedge clk);
      start = !m_busy && mc_start && (int'(mc_len) >= 2);
      if (exc_req)                     e_st = 6'b000000;
      else if (stallreq_mem)           e_st = 6'b011111;
      else if (m_busy && m_left > 1)   e_st = 6'b001111;
      else if (start)                  e_st = 6'b001111;
      else if (stallreq_id)            e_st = 6'b000111;
      else if (stallreq_if)            e_st = 6'b000011;
      else                             e_st = 6'b000000;
      e_br   = (br_req || m_pend) && !e_st[1] && !exc_req;
      e_done = m_busy && m_left == 1 && !stallreq_mem && !exc_req;
      chk("stall",     64'(stall),     64'(e_st));
      chk("br",        64'(br),        64'(e_br));
      chk("flush",     64'(flush),     64'(exc_req));
      chk("new_pc",    64'(new_pc),    exc_req ? 64'(exc_pc) : 64'd0);
      chk("mc_busy",   64'(mc_busy),   64'(m_busy));
      chk("mc_done",   64'(mc_done),   64'(e_done));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      @(posedge clk);
      if (e_st != 0 && m_cnt < PMAX) m_cnt++;
      if (exc_req) begin
         m_busy = 0; m_left = 0; m_pend = 0;
      end else begin
         if (m_busy) begin
            if (!stallreq_mem) m_left--;
            if (m_left == 0) m_busy = 0;
         end else if (start) begin
            m_busy = 1; m_left = int'(mc_len) - 1;
         end
         if (e_br) m_pend = 0;
         else if (br_req && e_st[1] && !e_st[2]) m_pend = 1;
      end
      #1;
   endtask

   task automatic check_reset_zero();
      chk("rst_stall",   64'(stall),     64'd0);
      chk("rst_br",      64'(br),        64'd0);
      chk("rst_flush",   64'(flush),     64'd0);
      chk("rst_new_pc",  64'(new_pc),    64'd0);
      chk("rst_mc_busy", 64'(mc_busy),   64'd0);
      chk("rst_mc_done", 64'(mc_done),   64'd0);
      chk("rst_cnt",     64'(stall_cnt), 64'd0);
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_zero();
      rst = 0;
      cyc();

      // multi-cycle op, length 4, undisturbed
      mc_start = 1; mc_len = 6'd4;
      cyc();
      mc_start = 0; mc_len = '0;
      repeat (4) cyc();

      // length 4 with two MEM stall cycles in the middle
      mc_start = 1; mc_len = 6'd4;
      cyc();
      mc_start = 0; mc_len = '0;
      cyc();
      stallreq_mem = 1;
      repeat (2) cyc();
      stallreq_mem = 0;
      repeat (3) cyc();

      // branch deferred by an IF stall
      br_req = 1; stallreq_if = 1;
      repeat (2) cyc();
      stallreq_if = 0;
      cyc();
      br_req = 0;
      repeat (2) cyc();

      // exception during MC_BUSY with a pending branch
      br_req = 1; stallreq_if = 1;
      cyc();
      br_req = 0; stallreq_if = 0;
      mc_start = 1; mc_len = 6'd5;
      cyc();
      mc_start = 0; mc_len = '0;
      cyc();
      exc_req = 1; exc_pc = 32'h0000_0100;
      cyc();
      exc_req = 0; exc_pc = '0;
      repeat (2) cyc();

      // simultaneous mc_start and exception
      mc_start = 1; mc_len = 6'd3; exc_req = 1; exc_pc = 32'h0000_0200;
      cyc();
      idle_inputs();
      repeat (2) cyc();

      // reset mid multi-cycle op, no clock edge needed
      mc_start = 1; mc_len = 6'd6; stallreq_if = 1;
      cyc();
      mc_start = 0;
      cyc();
      @(negedge clk);
      #1 rst = 1;
      #1;
      check_reset_zero();
      model_reset();
      @(posedge clk);
      #1;
      rst = 0;
      idle_inputs();
      cyc();

      // random traffic
      for (int i = 0; i < 600; i++) begin
         stallreq_if  = ($urandom_range(0, 9) < 3);
         stallreq_id  = ($urandom_range(0, 9) < 2);
         stallreq_mem = ($urandom_range(0, 9) < 2);
         mc_start     = ($urandom_range(0, 9) < 2);
         mc_len       = MCW'($urandom_range(0, 6));
         br_req       = ($urandom_range(0, 9) < 3);
         exc_req      = ($urandom_range(0, 39) == 0);
         exc_pc       = $urandom;
         cyc();
      end

      // saturation of the stall counter
      idle_inputs();
      rst = 1;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      rst = 0;
      stallreq_if = 1;
      repeat (300) cyc();
      chk("cnt_saturated", 64'(stall_cnt), 64'hFF);
      stallreq_if = 0;
      cyc();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
